// File: rtl/rf_writeback_port.sv
// Register-file write-back port: WB pipeline register, write-port arbiter
// and a small correction queue drained through idle write-port cycles.
module rf_writeback_port #(
  parameter int CORR_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic             s_clk_i,
  input  logic             s_reset_i,
  input  logic             s_flush_i,
  input  logic             s_ma_we_i,
  input  logic [4:0]       s_ma_rd_i,
  input  logic [31:0]      s_ma_val_i,
  input  logic             s_corr_req_i,
  input  logic [4:0]       s_corr_add_i,
  input  logic [31:0]      s_corr_val_i,
  output logic             s_mawb_we_o,
  output logic [4:0]       s_mawb_rd_o,
  output logic [31:0]      s_mawb_val_o,
  output logic             s_rf_we_o,
  output logic [4:0]       s_rf_add_o,
  output logic [31:0]      s_rf_val_o,
  output logic             s_corr_busy_o,
  output logic             s_corr_ovf_o,
  output logic [CNT_W-1:0] s_corr_drop_cnt_o
);

  localparam int PW = $clog2(CORR_DEPTH);
  localparam int IW = $clog2(CORR_DEPTH + 3);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(CORR_DEPTH);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CORR_DEPTH-1:0] q_vld;
  logic [CORR_DEPTH-1:0] clr;
  logic [4:0]            q_add [CORR_DEPTH];
  logic [31:0]           q_val [CORR_DEPTH];
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         wptr;
  logic [PW:0]           cnt;
  logic                  cap;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  push_req;
  logic                  push;
  logic                  drop;
  logic                  push_stale;
  logic [IW-1:0]         inc;
  logic [31:0]           cnt_sum;

  assign cap      = s_ma_we_i & ~s_flush_i & (s_ma_rd_i != 5'd0);
  assign empty    = (cnt == '0);
  assign full     = (cnt == FULL_CNT);
  assign pop      = ~s_mawb_we_o & ~empty;
  assign push_req = s_corr_req_i & (s_corr_add_i != 5'd0);
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // a new correction is already stale if the pipeline writes that register
  assign push_stale =
    (s_mawb_we_o & (s_corr_add_i == s_mawb_rd_o)) |
    (cap & (s_corr_add_i == s_ma_rd_i));

  assign s_corr_ovf_o  = drop;
  assign s_corr_busy_o = ~empty;

  always_comb begin
    clr = '0;
    for (int i = 0; i < CORR_DEPTH; i++) begin
      clr[i] = s_mawb_we_o & q_vld[i] &
               (q_add[i] == s_mawb_rd_o);
    end
  end

  always_comb begin
    inc = '0;
    for (int i = 0; i < CORR_DEPTH; i++) begin
      inc = inc + IW'(clr[i]);
    end
    inc = inc + IW'(push & push_stale) + IW'(drop);
  end

  assign cnt_sum = 32'(s_corr_drop_cnt_o) + 32'(inc);

  always_comb begin
    s_rf_we_o  = 1'b0;
    s_rf_add_o = '0;
    s_rf_val_o = '0;
    if (s_mawb_we_o) begin
      s_rf_we_o  = 1'b1;
      s_rf_add_o = s_mawb_rd_o;
      s_rf_val_o = s_mawb_val_o;
    end else if (!empty && q_vld[rptr]) begin
      s_rf_we_o  = 1'b1;
      s_rf_add_o = q_add[rptr];
      s_rf_val_o = q_val[rptr];
    end
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      s_mawb_we_o  <= 1'b0;
      s_mawb_rd_o  <= '0;
      s_mawb_val_o <= '0;
    end else begin
      s_mawb_we_o <= cap;
      if (cap) begin
        s_mawb_rd_o  <= s_ma_rd_i;
        s_mawb_val_o <= s_ma_val_i;
      end
    end
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      q_vld             <= '0;
      rptr              <= '0;
      wptr              <= '0;
      cnt               <= '0;
      s_corr_drop_cnt_o <= '0;
    end else begin
      q_vld <= q_vld & ~clr;
      if (pop) begin
        q_vld[rptr] <= 1'b0;
        rptr        <= rptr + 1'b1;
      end
      // push after pop: a full queue reuses the slot being freed
      if (push) begin
        q_vld[wptr] <= ~push_stale;
        wptr        <= wptr + 1'b1;
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
      if (inc != '0) begin
        s_corr_drop_cnt_o <= (cnt_sum > CNT_MAX) ?
          CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (push) begin
      q_add[wptr] <= s_corr_add_i;
      q_val[wptr] <= s_corr_val_i;
    end
  end

endmodule

// File: tb/tb_rf_writeback_port.sv
// Bench for rf_writeback_port: directed scenarios with constant
// expectations plus randomized traffic against a queue-based model.
module tb_rf_writeback_port;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ma_we;
  logic [4:0]  ma_rd;
  logic [31:0] ma_val;
  logic        creq;
  logic [4:0]  cadd;
  logic [31:0] cval;

  logic        mawb_we, rf_we, busy, ovf;
  logic [4:0]  mawb_rd, rf_add;
  logic [31:0] mawb_val, rf_val;
  logic [7:0]  cnt;

  logic        mawb_we2, rf_we2, busy2, ovf2;
  logic [4:0]  mawb_rd2, rf_add2;
  logic [31:0] mawb_val2, rf_val2;
  logic [1:0]  cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  rf_writeback_port #(.CORR_DEPTH(DEPTH), .CNT_W(8)) dut (
    .s_clk_i(clk), .s_reset_i(rst), .s_flush_i(flush),
    .s_ma_we_i(ma_we), .s_ma_rd_i(ma_rd), .s_ma_val_i(ma_val),
    .s_corr_req_i(creq), .s_corr_add_i(cadd), .s_corr_val_i(cval),
    .s_mawb_we_o(mawb_we), .s_mawb_rd_o(mawb_rd),
    .s_mawb_val_o(mawb_val), .s_rf_we_o(rf_we),
    .s_rf_add_o(rf_add), .s_rf_val_o(rf_val),
    .s_corr_busy_o(busy), .s_corr_ovf_o(ovf),
    .s_corr_drop_cnt_o(cnt)
  );

  rf_writeback_port #(.CORR_DEPTH(DEPTH), .CNT_W(2)) dut_s (
    .s_clk_i(clk), .s_reset_i(rst), .s_flush_i(flush),
    .s_ma_we_i(ma_we), .s_ma_rd_i(ma_rd), .s_ma_val_i(ma_val),
    .s_corr_req_i(creq), .s_corr_add_i(cadd), .s_corr_val_i(cval),
    .s_mawb_we_o(mawb_we2), .s_mawb_rd_o(mawb_rd2),
    .s_mawb_val_o(mawb_val2), .s_rf_we_o(rf_we2),
    .s_rf_add_o(rf_add2), .s_rf_val_o(rf_val2),
    .s_corr_busy_o(busy2), .s_corr_ovf_o(ovf2),
    .s_corr_drop_cnt_o(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue of pending corrections
  typedef struct {
    bit          v;
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_e;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_val;
  int          m_raw;
  bit          m_pop, m_preq, m_cap, m_drop, m_stale;

  initial begin
    mq.delete();
    m_we = 0; m_rd = 0; m_val = 0; m_raw = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_we = 0; m_rd = 0; m_val = 0; m_raw = 0;
      end else begin
        m_pop  = !m_we && mq.size() > 0;
        m_preq = creq && cadd != 5'd0;
        m_cap  = ma_we && !flush && ma_rd != 5'd0;
        m_drop = m_preq && mq.size() == DEPTH && !m_pop;
        if (m_we) begin
          foreach (mq[i]) begin
            if (mq[i].v && mq[i].a == m_rd) begin
              mq[i].v = 0;
              m_raw++;
            end
          end
        end
        if (m_pop) void'(mq.pop_front());
        if (m_preq && !m_drop) begin
          m_stale = (m_we && cadd == m_rd) || (m_cap && cadd == ma_rd);
          m_e.v = !m_stale;
          m_e.a = cadd;
          m_e.d = cval;
          mq.push_back(m_e);
          if (m_stale) m_raw++;
        end
        if (m_drop) m_raw++;
        m_we = m_cap;
        if (m_cap) begin
          m_rd  = ma_rd;
          m_val = ma_val;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic drv(input logic we, input logic [4:0] rd,
                     input logic [31:0] v, input logic fl,
                     input logic cr, input logic [4:0] ca,
                     input logic [31:0] cv);
    @(negedge clk);
    ma_we = we; ma_rd = rd; ma_val = v; flush = fl;
    creq = cr; cadd = ca; cval = cv;
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ma_we = 0; ma_rd = 0; ma_val = 0; flush = 0;
    creq = 0; cadd = 0; cval = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++; if (mawb_we !== 1'b0) begin n_fail++; $display("FAIL rst_mawb_we got %0h want 0", mawb_we); end
    n_tests++; if (mawb_rd !== 5'd0) begin n_fail++; $display("FAIL rst_mawb_rd got %0h want 0", mawb_rd); end
    n_tests++; if (mawb_val !== 32'd0) begin n_fail++; $display("FAIL rst_mawb_val got %0h want 0", mawb_val); end
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_rf_we got %0h want 0", rf_we); end
    n_tests++; if (rf_add !== 5'd0) begin n_fail++; $display("FAIL rst_rf_add got %0h want 0", rf_add); end
    n_tests++; if (rf_val !== 32'd0) begin n_fail++; $display("FAIL rst_rf_val got %0h want 0", rf_val); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0h want 0", busy); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %0h want 0", ovf); end
    n_tests++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt got %0h want 0", cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pipeline_write();
    do_reset();
    drv(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    idle();
    n_tests++; if (mawb_we !== 1'b1) begin n_fail++; $display("FAIL pw_mawb_we got %0h want 1", mawb_we); end
    n_tests++; if (mawb_rd !== 5'd5) begin n_fail++; $display("FAIL pw_mawb_rd got %0h want 5", mawb_rd); end
    n_tests++; if (mawb_val !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pw_mawb_val got %0h want deadbeef", mawb_val); end
    n_tests++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL pw_rf_we got %0h want 1", rf_we); end
    n_tests++; if (rf_add !== 5'd5) begin n_fail++; $display("FAIL pw_rf_add got %0h want 5", rf_add); end
    n_tests++; if (rf_val !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pw_rf_val got %0h want deadbeef", rf_val); end
    drv(1, 6, 32'h12345678, 1, 0, 0, 0);
    idle();
    n_tests++; if (mawb_we !== 1'b0) begin n_fail++; $display("FAIL flush_mawb_we got %0h want 0", mawb_we); end
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL flush_rf_we got %0h want 0", rf_we); end
    n_tests++; if (rf_add !== 5'd0) begin n_fail++; $display("FAIL flush_rf_add got %0h want 0", rf_add); end
    n_tests++; if (mawb_rd !== 5'd5) begin n_fail++; $display("FAIL flush_mawb_rd got %0h want 5", mawb_rd); end
    n_tests++; if (mawb_val !== 32'hDEADBEEF) begin n_fail++; $display("FAIL flush_mawb_val got %0h want deadbeef", mawb_val); end
    drv(1, 0, 32'hFFFF, 0, 0, 0, 0);
    idle();
    n_tests++; if (mawb_we !== 1'b0) begin n_fail++; $display("FAIL x0_mawb_we got %0h want 0", mawb_we); end
    n_tests++; if (mawb_rd !== 5'd5) begin n_fail++; $display("FAIL x0_mawb_rd got %0h want 5", mawb_rd); end
  endtask

  task automatic test_drain();
    do_reset();
    drv(1, 7, 32'h70, 0, 1, 3, 32'h11);
    drv(1, 8, 32'h80, 0, 1, 4, 32'h22);
    n_tests++; if (rf_add !== 5'd7 || rf_we !== 1'b1) begin n_fail++; $display("FAIL drain_p7 got we=%0h add=%0h want we=1 add=7", rf_we, rf_add); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_busy0 got %0h want 1", busy); end
    idle();
    n_tests++; if (rf_add !== 5'd8 || rf_val !== 32'h80) begin n_fail++; $display("FAIL drain_p8 got add=%0h val=%0h want add=8 val=80", rf_add, rf_val); end
    idle();
    n_tests++; if (rf_we !== 1'b1 || rf_add !== 5'd3 || rf_val !== 32'h11) begin n_fail++; $display("FAIL drain_c3 got we=%0h add=%0h val=%0h want 1/3/11", rf_we, rf_add, rf_val); end
    idle();
    n_tests++; if (rf_we !== 1'b1 || rf_add !== 5'd4 || rf_val !== 32'h22) begin n_fail++; $display("FAIL drain_c4 got we=%0h add=%0h val=%0h want 1/4/22", rf_we, rf_add, rf_val); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_busy1 got %0h want 1", busy); end
    idle();
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL drain_idle_we got %0h want 0", rf_we); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_busy2 got %0h want 0", busy); end
  endtask

  task automatic test_stale();
    do_reset();
    drv(1, 1, 32'h1, 0, 0, 0, 0);
    drv(1, 2, 32'h2, 0, 1, 9, 32'hAA);
    drv(1, 9, 32'h55, 0, 0, 0, 0);
    n_tests++; if (rf_add !== 5'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL stale_pre got add=%0h busy=%0h want add=2 busy=1", rf_add, busy); end
    idle();
    n_tests++; if (rf_we !== 1'b1 || rf_add !== 5'd9 || rf_val !== 32'h55) begin n_fail++; $display("FAIL stale_p9 got we=%0h add=%0h val=%0h want 1/9/55", rf_we, rf_add, rf_val); end
    n_tests++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL stale_cnt0 got %0d want 0", cnt); end
    idle();
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL stale_pop_we got %0h want 0", rf_we); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stale_busy got %0h want 1", busy); end
    n_tests++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL stale_cnt1 got %0d want 1", cnt); end
    idle();
    n_tests++; if (busy !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL stale_empty got busy=%0h we=%0h want 0/0", busy, rf_we); end
    drv(1, 12, 32'hC, 0, 1, 12, 32'hBAD);
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL stale_ovf got %0h want 0", ovf); end
    idle();
    n_tests++; if (rf_add !== 5'd12 || rf_val !== 32'hC) begin n_fail++; $display("FAIL stale_p12 got add=%0h val=%0h want c/c", rf_add, rf_val); end
    n_tests++; if (cnt !== 8'd2) begin n_fail++; $display("FAIL stale_cnt2 got %0d want 2", cnt); end
    idle();
    n_tests++; if (rf_we !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL stale_inv_pop got we=%0h busy=%0h want 0/1", rf_we, busy); end
    idle();
    n_tests++; if (busy !== 1'b0 || cnt !== 8'd2) begin n_fail++; $display("FAIL stale_end got busy=%0h cnt=%0d want 0/2", busy, cnt); end
  endtask

  task automatic test_overflow();
    do_reset();
    drv(1, 1, 32'h101, 0, 1, 3, 32'h3);
    drv(1, 2, 32'h102, 0, 1, 4, 32'h4);
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %0h want 0", ovf); end
    drv(1, 5, 32'h105, 0, 1, 6, 32'h6);
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %0h want 1", ovf); end
    n_tests++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL ovf_cnt0 got %0d want 0", cnt); end
    idle();
    n_tests++; if (ovf !== 1'b0 || cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_after got ovf=%0h cnt=%0d want 0/1", ovf, cnt); end
    n_tests++; if (rf_add !== 5'd5 || busy !== 1'b1) begin n_fail++; $display("FAIL ovf_p5 got add=%0h busy=%0h want 5/1", rf_add, busy); end
    drv(0, 0, 0, 0, 1, 10, 32'hA0);
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_poppush got %0h want 0", ovf); end
    n_tests++; if (rf_we !== 1'b1 || rf_add !== 5'd3 || rf_val !== 32'h3) begin n_fail++; $display("FAIL ovf_c3 got we=%0h add=%0h val=%0h want 1/3/3", rf_we, rf_add, rf_val); end
    idle();
    n_tests++; if (rf_add !== 5'd4 || cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_c4 got add=%0h cnt=%0d want 4/1", rf_add, cnt); end
    idle();
    n_tests++; if (rf_add !== 5'd10 || rf_val !== 32'hA0) begin n_fail++; $display("FAIL ovf_c10 got add=%0h val=%0h want a/a0", rf_add, rf_val); end
    idle();
    n_tests++; if (busy !== 1'b0 || cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_end got busy=%0h cnt=%0d want 0/1", busy, cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drv(1, 1, 32'h1, 0, 1, 3, 32'h33);
    drv(1, 2, 32'h2, 0, 1, 4, 32'h44);
    drv(1, 5, 32'h5, 0, 0, 0, 0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre_busy got %0h want 1", busy); end
    ma_we = 0; ma_rd = 0; ma_val = 0;
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (rf_we !== 1'b0 || rf_add !== 5'd0) begin n_fail++; $display("FAIL mid_rf got we=%0h add=%0h want 0/0", rf_we, rf_add); end
    n_tests++; if (mawb_we !== 1'b0 || mawb_rd !== 5'd0 || mawb_val !== 32'd0) begin n_fail++; $display("FAIL mid_mawb got %0h/%0h/%0h want 0/0/0", mawb_we, mawb_rd, mawb_val); end
    n_tests++; if (busy !== 1'b0 || cnt !== 8'd0) begin n_fail++; $display("FAIL mid_q got busy=%0h cnt=%0d want 0/0", busy, cnt); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle();
      n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_post_we%0d got %0h want 0", i, rf_we); end
    end
    drv(0, 0, 0, 0, 1, 0, 32'h99);
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL x0_ovf got %0h want 0", ovf); end
    idle();
    n_tests++; if (busy !== 1'b0 || cnt !== 8'd0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_req got busy=%0h cnt=%0d we=%0h want 0/0/0", busy, cnt, rf_we); end
  endtask

  task automatic test_saturation();
    int drops;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drv(1, 1, 32'(i), 0, 1, 5'(20 + i), 32'(i));
      drops = (i > 2) ? i - 2 : 0;
      n_tests++; if (cnt !== 8'(drops)) begin n_fail++; $display("FAIL sat_cnt%0d got %0d want %0d", i, cnt, drops); end
      n_tests++; if (cnt2 !== 2'((drops > 3) ? 3 : drops)) begin n_fail++; $display("FAIL sat_cnt2_%0d got %0d want %0d", i, cnt2, (drops > 3) ? 3 : drops); end
      n_tests++; if (ovf !== (i >= 2)) begin n_fail++; $display("FAIL sat_ovf%0d got %0h want %0h", i, ovf, i >= 2); end
    end
    idle();
    n_tests++; if (cnt !== 8'd5 || cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_final got %0d/%0d want 5/3", cnt, cnt2); end
    idle();
    idle();
    n_tests++; if (cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_hold got %0d want 3", cnt2); end
  endtask

  task automatic test_random();
    bit          e_we, e_ovf, e_pop, e_busy;
    logic [4:0]  e_add;
    logic [31:0] e_val;
    logic [7:0]  e_cnt;
    logic [1:0]  e_cnt2;
    int          we_pct;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      we_pct = ((i / 40) % 2 == 1) ? 85 : 30;
      drv($urandom_range(99, 0) < we_pct, 5'($urandom_range(7, 0)),
          $urandom, $urandom_range(7, 0) == 0,
          $urandom_range(1, 0) == 1, 5'($urandom_range(7, 0)),
          $urandom);
      e_pop = !m_we && mq.size() > 0;
      if (m_we) begin
        e_we = 1; e_add = m_rd; e_val = m_val;
      end else if (mq.size() > 0 && mq[0].v) begin
        e_we = 1; e_add = mq[0].a; e_val = mq[0].d;
      end else begin
        e_we = 0; e_add = 0; e_val = 0;
      end
      e_ovf  = creq && cadd != 0 && mq.size() == DEPTH && !e_pop;
      e_busy = mq.size() != 0;
      e_cnt  = 8'((m_raw > 255) ? 255 : m_raw);
      e_cnt2 = 2'((m_raw > 3) ? 3 : m_raw);
      n_tests++; if (rf_we !== e_we) begin n_fail++; $display("FAIL rnd_rf_we@%0d got %0h want %0h", i, rf_we, e_we); end
      n_tests++; if (rf_add !== e_add) begin n_fail++; $display("FAIL rnd_rf_add@%0d got %0h want %0h", i, rf_add, e_add); end
      n_tests++; if (rf_val !== e_val) begin n_fail++; $display("FAIL rnd_rf_val@%0d got %0h want %0h", i, rf_val, e_val); end
      n_tests++; if (ovf !== e_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d got %0h want %0h", i, ovf, e_ovf); end
      n_tests++; if (mawb_we !== m_we) begin n_fail++; $display("FAIL rnd_mawb_we@%0d got %0h want %0h", i, mawb_we, m_we); end
      n_tests++; if (mawb_rd !== m_rd || mawb_val !== m_val) begin n_fail++; $display("FAIL rnd_mawb@%0d got %0h/%0h want %0h/%0h", i, mawb_rd, mawb_val, m_rd, m_val); end
      n_tests++; if (busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy@%0d got %0h want %0h", i, busy, e_busy); end
      n_tests++; if (cnt !== e_cnt) begin n_fail++; $display("FAIL rnd_cnt@%0d got %0d want %0d", i, cnt, e_cnt); end
      n_tests++; if (cnt2 !== e_cnt2) begin n_fail++; $display("FAIL rnd_cnt2@%0d got %0d want %0d", i, cnt2, e_cnt2); end
      n_tests++; if ({rf_we2, rf_add2, rf_val2, ovf2, mawb_we2, mawb_rd2, mawb_val2, busy2} !==
                     {e_we, e_add, e_val, e_ovf, m_we, m_rd, m_val, e_busy}) begin
        n_fail++; $display("FAIL rnd_dut2@%0d got we=%0h add=%0h val=%0h want we=%0h add=%0h val=%0h", i, rf_we2, rf_add2, rf_val2, e_we, e_add, e_val);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    ma_we = 0; ma_rd = 0; ma_val = 0; flush = 0;
    creq = 0; cadd = 0; cval = 0;
    test_reset();
    test_pipeline_write();
    test_drain();
    test_stale();
    test_overflow();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
